s4_maxpool_2x2: RTL and testbench

//   S4 subsampling stage placed directly after the C3 ReLU/quantiser. Consumes the
//   two-channel 8-bit C3 feature stream (raster order, one pixel per channel per

---
 rtl/s4_maxpool_2x2.sv | 121 ++++++++++++
 tb/tb_s4_maxpool_2x2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/s4_maxpool_2x2.sv
// s4_maxpool_2x2: 2x2 stride-2 max pooling of the two-channel C3 feature stream.
// Ports:
//   clk                 - single clock, all logic on posedge
//   rst                 - synchronous active-high reset (priority over c3_valid)
//   c3_valid            - input beat strobe
//   c3_out_0/c3_out_1   - unsigned channel pixels, raster order
//   s4_valid            - one-cycle strobe, pooled pixel pair valid
//   s4_out_0/s4_out_1   - pooled pixels (hold between strobes)
//   s4_last             - with s4_valid on the last pooled pixel of a frame
module s4_maxpool_2x2 #(
  parameter int unsigned DW   = 8,
  parameter int unsigned IN_W = 10,
  parameter int unsigned IN_H = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c3_valid,
  input  logic [DW-1:0] c3_out_0,
  input  logic [DW-1:0] c3_out_1,
  output logic          s4_valid,
  output logic [DW-1:0] s4_out_0,
  output logic [DW-1:0] s4_out_1,
  output logic          s4_last
);

  localparam int unsigned CW  = $clog2(IN_W);
  localparam int unsigned RW  = $clog2(IN_H);
  localparam int unsigned LBN = IN_W / 2;
  localparam int unsigned LIW = (LBN > 1) ? $clog2(LBN) : 1;

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [DW-1:0]  hmax0_q, hmax0_d, hmax1_q, hmax1_d;
  logic           vld_q, vld_d, last_q, last_d;
  logic [DW-1:0]  out0_q, out0_d, out1_q, out1_d;
  logic [DW-1:0]  lb0_q [LBN];
  logic [DW-1:0]  lb1_q [LBN];

  logic           last_col_c, last_row_c, lb_we_c;
  logic [LIW-1:0] lb_idx_c;
  logic [DW-1:0]  pmax0_c, pmax1_c, lbr0_c, lbr1_c;

  // Horizontal pair max and line-buffer read for the current column pair.
  assign last_col_c = (col_q == CW'(IN_W - 1));
  assign last_row_c = (row_q == RW'(IN_H - 1));
  assign lb_idx_c   = LIW'(col_q >> 1);
  assign pmax0_c    = (c3_out_0 > hmax0_q) ? c3_out_0 : hmax0_q;
  assign pmax1_c    = (c3_out_1 > hmax1_q) ? c3_out_1 : hmax1_q;
  assign lbr0_c     = lb0_q[lb_idx_c];
  assign lbr1_c     = lb1_q[lb_idx_c];

  // Next-state: counters, horizontal hold, pooled outputs.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hmax0_d = hmax0_q;
    hmax1_d = hmax1_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    out0_d  = out0_q;
    out1_d  = out1_q;
    lb_we_c = 1'b0;
    if (c3_valid) begin
      if (!col_q[0]) begin
        hmax0_d = c3_out_0;
        hmax1_d = c3_out_1;
      end else if (!row_q[0]) begin
        lb_we_c = 1'b1;
      end else begin
        // Bottom-right pixel of the window: combine with the stored top pair.
        vld_d  = 1'b1;
        out0_d = (lbr0_c > pmax0_c) ? lbr0_c : pmax0_c;
        out1_d = (lbr1_c > pmax1_c) ? lbr1_c : pmax1_c;
        last_d = last_col_c && last_row_c;
      end
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hmax0_q <= '0;
      hmax1_q <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hmax0_q <= hmax0_d;
      hmax1_q <= hmax1_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  // Line buffer of even-row pair maxima; always written before it is read.
  always_ff @(posedge clk) begin
    if (!rst && lb_we_c) begin
      lb0_q[lb_idx_c] <= pmax0_c;
      lb1_q[lb_idx_c] <= pmax1_c;
    end
  end

  assign s4_valid = vld_q;
  assign s4_out_0 = out0_q;
  assign s4_out_1 = out1_q;
  assign s4_last  = last_q;

endmodule

// File: tb/tb_s4_maxpool_2x2.sv
// tb_s4_maxpool_2x2: directed self-checking bench for s4_maxpool_2x2.
// A frame-array reference checks every output cycle; directed checks use
// hand-computed pooled values.
module tb_s4_maxpool_2x2;

  localparam int unsigned DW   = 8;
  localparam int unsigned IN_W = 10;
  localparam int unsigned IN_H = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          c3_valid;
  logic [DW-1:0] c3_out_0, c3_out_1;
  logic          s4_valid, s4_last;
  logic [DW-1:0] s4_out_0, s4_out_1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [DW-1:0] o0;
    logic [DW-1:0] o1;
    logic          l;
  } out_t;
  out_t got_q[$];

  always #5 clk = ~clk;

  s4_maxpool_2x2 #(.DW(DW), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk      (clk),
    .rst      (rst),
    .c3_valid (c3_valid),
    .c3_out_0 (c3_out_0),
    .c3_out_1 (c3_out_1),
    .s4_valid (s4_valid),
    .s4_out_0 (s4_out_0),
    .s4_out_1 (s4_out_1),
    .s4_last  (s4_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: keeps the whole frame, predicts next-cycle outputs from inputs
  // that are stable at the falling edge.
  logic [DW-1:0] p0 [IN_H][IN_W];
  logic [DW-1:0] p1 [IN_H][IN_W];
  int            mr = 0, mc = 0;
  bit            seen_rst = 1'b0;
  logic          exp_v = 1'b0, exp_l = 1'b0;
  logic [DW-1:0] exp_o0 = '0, exp_o1 = '0;

  always @(negedge clk) begin
    if (seen_rst) begin
      chk("s4_valid", 32'(s4_valid), 32'(exp_v));
      chk("s4_last",  32'(s4_last),  32'(exp_l));
      chk("s4_out_0", 32'(s4_out_0), 32'(exp_o0));
      chk("s4_out_1", 32'(s4_out_1), 32'(exp_o1));
      if (s4_valid === 1'b1) got_q.push_back('{s4_out_0, s4_out_1, s4_last});
    end
    exp_v = 1'b0;
    exp_l = 1'b0;
    if (rst === 1'b1) begin
      seen_rst = 1'b1;
      mr = 0;
      mc = 0;
      exp_o0 = '0;
      exp_o1 = '0;
    end else if (c3_valid === 1'b1) begin
      p0[mr][mc] = c3_out_0;
      p1[mr][mc] = c3_out_1;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        exp_v  = 1'b1;
        exp_l  = (mr == IN_H - 1) && (mc == IN_W - 1);
        exp_o0 = max4(p0[mr-1][mc-1], p0[mr-1][mc], p0[mr][mc-1], p0[mr][mc]);
        exp_o1 = max4(p1[mr-1][mc-1], p1[mr-1][mc], p1[mr][mc-1], p1[mr][mc]);
      end
      if (mc == IN_W - 1) begin
        mc = 0;
        mr = (mr == IN_H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  end

  task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
    c3_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    c3_valid = 1'b1;
    c3_out_0 = a;
    c3_out_1 = b;
    @(posedge clk); #1;
    c3_valid = 1'b0;
  endtask

  task automatic ramp_frame(input int off, input int maxgap);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        beat(8'(r * 10 + c + off), 8'(r * 10 + c + off),
             (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic idle(input int n);
    c3_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    c3_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Ramp pooled value at window k is the bottom-right pixel (2r+1)*10+(2c+1).
  task automatic check_ramp(input string tag, input int base, input int off);
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("%s_o0[%0d]", tag, k), 32'(got_q[base+k].o0),
          32'((2 * (k / 5) + 1) * 10 + 2 * (k % 5) + 1 + off));
      chk($sformatf("%s_o1[%0d]", tag, k), 32'(got_q[base+k].o1),
          32'((2 * (k / 5) + 1) * 10 + 2 * (k % 5) + 1 + off));
      chk($sformatf("%s_last[%0d]", tag, k), 32'(got_q[base+k].l), 32'(k == 24));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlast;
    // Test 1: reset held with active input beats.
    rst = 1'b1; c3_valid = 1'b1; c3_out_0 = 8'd77; c3_out_1 = 8'd99;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_valid", 32'(s4_valid), 32'd0);
    chk("t1_out0",  32'(s4_out_0), 32'd0);
    chk("t1_out1",  32'(s4_out_1), 32'd0);
    chk("t1_last",  32'(s4_last),  32'd0);
    rst = 1'b0; c3_valid = 1'b0;
    idle(3);
    chk("t1_no_pulse", 32'(got_q.size()), 32'd0);

    // Test 2: back-to-back ramp frame.
    got_q.delete();
    ramp_frame(0, 0);
    idle(3);
    chk("t2_count", 32'(got_q.size()), 32'd25);
    chk("t2_first", 32'(got_q[0].o0), 32'd11);
    chk("t2_second", 32'(got_q[1].o0), 32'd13);
    chk("t2_lastval", 32'(got_q[24].o0), 32'd99);
    chk("t2_lastflag", 32'(got_q[24].l), 32'd1);
    check_ramp("t2", 0, 0);

    // Test 3: maximum in each of the four window positions.
    for (int pos = 0; pos < 4; pos++) begin
      do_reset();
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
        int wp;
        wp = ((i / 10) < 2 && (i % 10) < 2) ? (i / 10) * 2 + (i % 10) : -1;
        if (wp < 0)        beat(8'd0, 8'd0, 0);
        else if (wp == pos) beat(8'd200, 8'd250, 0);
        else               beat(8'(3 + wp), 8'(1 + wp), 0);
      end
      idle(3);
      chk($sformatf("t3_count_p%0d", pos), 32'(got_q.size()), 32'd1);
      chk($sformatf("t3_ch0_p%0d", pos), 32'(got_q[0].o0), 32'd200);
      chk($sformatf("t3_ch1_p%0d", pos), 32'(got_q[0].o1), 32'd250);
    end

    // Test 4: random gaps of 0..5 idle cycles.
    do_reset();
    got_q.delete();
    ramp_frame(0, 5);
    idle(3);
    chk("t4_count", 32'(got_q.size()), 32'd25);
    check_ramp("t4", 0, 0);

    // Test 5: two frames without an idle gap, second offset by 100.
    do_reset();
    got_q.delete();
    ramp_frame(0, 0);
    ramp_frame(100, 0);
    idle(3);
    chk("t5_count", 32'(got_q.size()), 32'd50);
    chk("t5_last25", 32'(got_q[24].l), 32'd1);
    chk("t5_last50", 32'(got_q[49].l), 32'd1);
    chk("t5_f2_first", 32'(got_q[25].o0), 32'd111);
    chk("t5_f2_lastval", 32'(got_q[49].o0), 32'd199);
    nlast = 0;
    foreach (got_q[k]) if (got_q[k].l) nlast++;
    chk("t5_nlast", 32'(nlast), 32'd2);
    check_ramp("t5f2", 25, 100);

    // Test 6: reset after 37 beats of bright data, then a clean frame.
    do_reset();
    for (int i = 0; i < 37; i++) beat(8'd250, 8'd250, 0);
    do_reset();
    got_q.delete();
    ramp_frame(0, 0);
    idle(3);
    chk("t6_count", 32'(got_q.size()), 32'd25);
    check_ramp("t6", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
